// File: rtl/washer_pkg.sv
// Shared washer definitions: machine state codes.
// Code 7 is unused and handled as power-off by consumers.
package washer_pkg;

    typedef enum logic [2:0] {
        shutDownST = 3'd0,
        beginST    = 3'd1,
        setST      = 3'd2,
        runST      = 3'd3,
        errorST    = 3'd4,
        pauseST    = 3'd5,
        finishST   = 3'd6
    } state_t;

endpackage

// File: rtl/bin_to_bcd99.sv
// Binary to 2-digit BCD, saturating at 99.
// Ports: bin (W bits) in; tens, units (4 bits each) out.
module bin_to_bcd99 #(
    parameter int W = 7
) (
    input  logic [W-1:0] bin,
    output logic [3:0]   tens,
    output logic [3:0]   units
);

    // Wide enough to hold 99 even for narrow inputs.
    localparam int IW = (W > 7) ? W : 7;

    logic [IW-1:0] v;

    always_comb begin
        v = IW'(bin);
        if (v > IW'(99))
            v = IW'(99);
        tens  = 4'(v / IW'(10));
        units = 4'(v % IW'(10));
    end

endmodule

// File: rtl/stage_view_ctrl.sv
// Washer front-panel view: stage totals, LEDs with blink, 4-digit scan.
// Ports: cp, rst_n, state, src_times, run_times, src_sel in;
//        total_time, cur_stage, cur_time, stage_led, power_led,
//        set_led, digit_sel, digit_bcd out (all registered).
module stage_view_ctrl
    import washer_pkg::*;
#(
    parameter int NUM_STAGES = 8,
    parameter int STAGE_W    = 4,
    parameter int BLINK_DIV  = 25_000_000,
    parameter int SCAN_DIV   = 50_000,
    localparam int IDX_W     = $clog2(NUM_STAGES + 1),
    localparam int SUM_W     = STAGE_W + $clog2(NUM_STAGES)
) (
    input  logic                          cp,
    input  logic                          rst_n,
    input  logic [2:0]                    state,
    input  logic [NUM_STAGES*STAGE_W-1:0] src_times,
    input  logic [NUM_STAGES*STAGE_W-1:0] run_times,
    input  logic [NUM_STAGES-1:0]         src_sel,
    output logic [SUM_W-1:0]              total_time,
    output logic [IDX_W-1:0]              cur_stage,
    output logic [STAGE_W-1:0]            cur_time,
    output logic [NUM_STAGES-1:0]         stage_led,
    output logic                          power_led,
    output logic                          set_led,
    output logic [3:0]                    digit_sel,
    output logic [3:0]                    digit_bcd
);

    localparam int BW = $clog2(BLINK_DIV);
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [NUM_STAGES*STAGE_W-1:0] fields;
    logic [NUM_STAGES-1:0]         nz;
    logic [SUM_W-1:0]              sum;
    logic [IDX_W-1:0]              idx;
    logic [STAGE_W-1:0]            ctime;

    // Lowest nonzero stage wins: scan downward so the last hit is lowest.
    always_comb begin
        fields = (state == setST) ? src_times : run_times;
        nz     = '0;
        sum    = '0;
        idx    = IDX_W'(NUM_STAGES);
        ctime  = '0;
        for (int i = NUM_STAGES - 1; i >= 0; i--) begin
            nz[i] = |fields[i*STAGE_W +: STAGE_W];
            sum   = sum + SUM_W'(fields[i*STAGE_W +: STAGE_W]);
            if (nz[i]) begin
                idx   = IDX_W'(i);
                ctime = fields[i*STAGE_W +: STAGE_W];
            end
        end
    end

    logic [2:0]    state_q;
    logic [BW-1:0] blink_cnt;
    logic          blink_ph;
    logic          chg;
    logic          bwrap;
    logic          ph_n;

    assign chg   = state != state_q;
    assign bwrap = blink_cnt == BW'(BLINK_DIV - 1);
    // LEDs use the next phase so a new state shows on from its first cp.
    assign ph_n  = chg ? 1'b1 : (bwrap ? ~blink_ph : blink_ph);

    always_ff @(posedge cp or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= '0;
            blink_cnt <= '0;
            blink_ph  <= 1'b0;
        end else begin
            state_q   <= state;
            blink_cnt <= (chg || bwrap) ? '0 : blink_cnt + 1'b1;
            blink_ph  <= ph_n;
        end
    end

    logic [NUM_STAGES-1:0] led_n;
    logic                  pwr_n;
    logic                  set_n;
    logic                  blank;

    always_comb begin
        led_n = '0;
        pwr_n = 1'b0;
        set_n = 1'b0;
        blank = 1'b0;
        case (state)
            beginST: pwr_n = 1'b1;
            setST: begin
                led_n = src_sel;
                pwr_n = 1'b1;
                set_n = 1'b1;
            end
            runST: begin
                led_n = nz;
                for (int i = 0; i < NUM_STAGES; i++)
                    if (IDX_W'(i) == idx)
                        led_n[i] = nz[i] & ph_n;
                pwr_n = 1'b1;
            end
            pauseST: begin
                led_n = nz;
                pwr_n = 1'b1;
            end
            errorST: begin
                led_n = {NUM_STAGES{ph_n}};
                pwr_n = 1'b1;
            end
            finishST: pwr_n = ph_n;
            default: blank = 1'b1;
        endcase
    end

    logic [SW-1:0] scan_cnt;
    logic [1:0]    dig;

    always_ff @(posedge cp or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt <= '0;
            dig      <= '0;
        end else if (scan_cnt == SW'(SCAN_DIV - 1)) begin
            scan_cnt <= '0;
            dig      <= dig + 2'd1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    logic [3:0] tot_t;
    logic [3:0] tot_u;
    logic [3:0] cur_t;
    logic [3:0] cur_u;
    logic [3:0] bcd_n;

    bin_to_bcd99 #(.W(SUM_W)) u_tot (
        .bin   (sum),
        .tens  (tot_t),
        .units (tot_u)
    );

    bin_to_bcd99 #(.W(STAGE_W)) u_cur (
        .bin   (ctime),
        .tens  (cur_t),
        .units (cur_u)
    );

    always_comb begin
        case (dig)
            2'd3:    bcd_n = tot_t;
            2'd2:    bcd_n = tot_u;
            2'd1:    bcd_n = cur_t;
            default: bcd_n = cur_u;
        endcase
    end

    always_ff @(posedge cp or negedge rst_n) begin
        if (!rst_n) begin
            total_time <= '0;
            cur_stage  <= '0;
            cur_time   <= '0;
            stage_led  <= '0;
            power_led  <= 1'b0;
            set_led    <= 1'b0;
            digit_sel  <= '0;
            digit_bcd  <= '0;
        end else begin
            total_time <= sum;
            cur_stage  <= idx;
            cur_time   <= ctime;
            stage_led  <= led_n;
            power_led  <= pwr_n;
            set_led    <= set_n;
            digit_sel  <= blank ? 4'b0000 : (4'b0001 << dig);
            digit_bcd  <= blank ? 4'hF : bcd_n;
        end
    end

endmodule
